// File: rtl/rv_enc_pkg.sv
// Shared constants for the RV32I instruction encoder: format codes, the NOP
// word substituted for unencodable input, and base opcodes.
package rv_enc_pkg;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

endpackage

// File: rtl/imm_scatter.sv
// Scatters a full 32-bit immediate into its instruction-word bit positions.
// Define IMMENC_RANGE_CHECK_EN to flag immediates the format cannot represent.
module imm_scatter
  import rv_enc_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [31:0] imm,
  output logic [31:0] imm_bits,
  output logic        range_err
);

  always_comb begin
    imm_bits = '0;
    case (fmt)
      FMT_I: imm_bits[31:20] = imm[11:0];
      FMT_S: begin
        imm_bits[31:25] = imm[11:5];
        imm_bits[11:7]  = imm[4:0];
      end
      FMT_B: begin
        imm_bits[31]    = imm[12];
        imm_bits[30:25] = imm[10:5];
        imm_bits[11:8]  = imm[4:1];
        imm_bits[7]     = imm[11];
      end
      FMT_U: imm_bits[31:12] = imm[31:12];
      FMT_J: begin
        imm_bits[31]    = imm[20];
        imm_bits[30:21] = imm[10:1];
        imm_bits[20]    = imm[11];
        imm_bits[19:12] = imm[19:12];
      end
      default: imm_bits = '0;
    endcase
  end

`ifdef IMMENC_RANGE_CHECK_EN
  // Upper bits must be a pure sign extension; branch/jump offsets must be even.
  always_comb begin
    range_err = 1'b0;
    case (fmt)
      FMT_I, FMT_S: range_err = (imm[31:11] != {21{imm[11]}});
      FMT_B:        range_err = (imm[31:12] != {20{imm[12]}}) || imm[0];
      FMT_J:        range_err = (imm[31:20] != {12{imm[20]}}) || imm[0];
      FMT_U:        range_err = (imm[11:0] != 12'd0);
      default:      range_err = 1'b0;
    endcase
  end
`else
  logic unused_imm_lsb;
  assign unused_imm_lsb = imm[0];
  assign range_err      = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Packs decoded RV32I fields into instruction words behind a one-stage
// valid/ready register, tagging each with its memory address. Option: IMMENC_RANGE_CHECK_EN.
module instr_encoder
  import rv_enc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ADDR_STEP = 32'd4,
  parameter int          ERR_CNT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [2:0]           fmt_i,
  input  logic [6:0]           opcode_i,
  input  logic [2:0]           funct3_i,
  input  logic [6:0]           funct7_i,
  input  logic [4:0]           rd_i,
  input  logic [4:0]           rs1_i,
  input  logic [4:0]           rs2_i,
  input  logic [31:0]          imm_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [31:0]          instr_o,
  output logic [31:0]          addr_o,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  logic [31:0] imm_bits;
  logic        range_err;
  logic [31:0] enc_word;
  logic        enc_err;
  logic [31:0] addr_cnt;
  logic        accept;

  imm_scatter u_imm_scatter (
    .fmt       (fmt_i),
    .imm       (imm_i),
    .imm_bits  (imm_bits),
    .range_err (range_err)
  );

  assign ready_o = !valid_o || ready_i;
  assign accept  = valid_i && ready_o;

  // Register fields are placed only where the format uses them; the rest stay zero.
  always_comb begin
    enc_word = '0;
    enc_err  = 1'b0;
    case (fmt_i)
      FMT_R:        enc_word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      FMT_I:        enc_word = {12'd0, rs1_i, funct3_i, rd_i, opcode_i};
      FMT_S, FMT_B: enc_word = {7'd0, rs2_i, rs1_i, funct3_i, 5'd0, opcode_i};
      FMT_U, FMT_J: enc_word = {20'd0, rd_i, opcode_i};
      default:      enc_err  = 1'b1;
    endcase
    enc_word = enc_word | imm_bits;
    if (enc_err || range_err) begin
      enc_word = NOP_INSTR;
      enc_err  = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_o   <= 1'b0;
      instr_o   <= '0;
      addr_o    <= BASE_ADDR;
      err_o     <= 1'b0;
      err_cnt_o <= '0;
      addr_cnt  <= BASE_ADDR;
    end else if (accept) begin
      valid_o  <= 1'b1;
      instr_o  <= enc_word;
      err_o    <= enc_err;
      addr_o   <= addr_cnt;
      addr_cnt <= addr_cnt + ADDR_STEP;
      if (enc_err && (err_cnt_o != '1))
        err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder; BASE_ADDR sits near the top
// of the address space so the counter wraps during the run.
module tb_instr_encoder;
  import rv_enc_pkg::*;

  localparam logic [31:0] BASE = 32'hFFFF_FFE0;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        valid_i;
  logic        ready_o;
  logic [2:0]  fmt_i;
  logic [6:0]  opcode_i;
  logic [2:0]  funct3_i;
  logic [6:0]  funct7_i;
  logic [4:0]  rd_i;
  logic [4:0]  rs1_i;
  logic [4:0]  rs2_i;
  logic [31:0] imm_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] instr_o;
  logic [31:0] addr_o;
  logic        err_o;
  logic [7:0]  err_cnt_o;

  int tests_run = 0;
  int tests_failed = 0;
  int exp_err_cnt = 0;

  instr_encoder #(.BASE_ADDR(BASE), .ADDR_STEP(32'd4), .ERR_CNT_W(8)) dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .fmt_i     (fmt_i),
    .opcode_i  (opcode_i),
    .funct3_i  (funct3_i),
    .funct7_i  (funct7_i),
    .rd_i      (rd_i),
    .rs1_i     (rs1_i),
    .rs2_i     (rs2_i),
    .imm_i     (imm_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .instr_o   (instr_o),
    .addr_o    (addr_o),
    .err_o     (err_o),
    .err_cnt_o (err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] addr_of(input int n);
    return BASE + 32'(n) * 32'd4;
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] exp_instr,
                             input logic [31:0] exp_addr, input logic exp_err);
    check32({tag, ".valid"}, {31'd0, valid_o}, 32'd1);
    check32({tag, ".instr"}, instr_o, exp_instr);
    check32({tag, ".addr"}, addr_o, exp_addr);
    check32({tag, ".err"}, {31'd0, err_o}, {31'd0, exp_err});
    check32({tag, ".errcnt"}, {24'd0, err_cnt_o}, 32'(exp_err_cnt));
  endtask

  task automatic set_fields(input logic [2:0] fmt, input logic [6:0] opc, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [31:0] imm);
    fmt_i = fmt; opcode_i = opc; funct3_i = f3; funct7_i = f7;
    rd_i = rd; rs1_i = rs1; rs2_i = rs2; imm_i = imm;
    valid_i = 1'b1;
  endtask

  task automatic applyStimulus(input logic [2:0] fmt, input logic [6:0] opc, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [31:0] imm);
    set_fields(fmt, opc, f3, f7, rd, rs1, rs2, imm);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
  endtask

  initial begin
    rst_n_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    set_fields(FMT_R, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check32("rst.valid", {31'd0, valid_o}, 32'd0);
    check32("rst.instr", instr_o, 32'd0);
    check32("rst.addr", addr_o, BASE);
    check32("rst.err", {31'd0, err_o}, 32'd0);
    check32("rst.errcnt", {24'd0, err_cnt_o}, 32'd0);
    check32("rst.ready", {31'd0, ready_o}, 32'd1);
    #3 rst_n_i = 1'b1;
    @(posedge clk_i); #1;

    // Unused fields carry junk to prove they are masked off.
    applyStimulus(FMT_I, OPC_OP_IMM, 3'd0, 7'h7F, 5'd1, 5'd0, 5'd31, 32'd5);
    checkOutput("addi", 32'h0050_0093, addr_of(0), 1'b0);
    applyStimulus(FMT_S, OPC_STORE, 3'b010, 7'h55, 5'd31, 5'd1, 5'd2, 32'd8);
    checkOutput("sw", 32'h0020_A423, addr_of(1), 1'b0);
    applyStimulus(FMT_B, OPC_BRANCH, 3'd0, 7'h7F, 5'd17, 5'd1, 5'd2, 32'hFFFF_FFFC);
    checkOutput("beq", 32'hFE20_8EE3, addr_of(2), 1'b0);
    applyStimulus(FMT_R, OPC_OP, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'hFFFF_FFFF);
    checkOutput("add", 32'h0020_81B3, addr_of(3), 1'b0);
    applyStimulus(FMT_R, OPC_OP, 3'd0, 7'b0100000, 5'd3, 5'd1, 5'd2, 32'd0);
    checkOutput("sub", 32'h4020_81B3, addr_of(4), 1'b0);
    applyStimulus(FMT_U, OPC_LUI, 3'd7, 7'h7F, 5'd5, 5'd31, 5'd31, 32'h1234_5000);
    checkOutput("lui", 32'h1234_52B7, addr_of(5), 1'b0);
    applyStimulus(FMT_J, OPC_JAL, 3'd7, 7'h7F, 5'd1, 5'd31, 5'd31, 32'd8);
    checkOutput("jal+8", 32'h0080_00EF, addr_of(6), 1'b0);
    applyStimulus(FMT_J, OPC_JAL, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC);
    checkOutput("jal-4", 32'hFFDF_F06F, addr_of(7), 1'b0);

    // Address wraps past 0xFFFF_FFFC here.
    applyStimulus(FMT_I, OPC_OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
`ifdef IMMENC_RANGE_CHECK_EN
    exp_err_cnt = 1;
    checkOutput("range", NOP_INSTR, addr_of(8), 1'b1);
`else
    checkOutput("range", 32'h8000_0093, addr_of(8), 1'b0);
`endif
    check32("wrap.addr", addr_o, 32'h0000_0000);

    applyStimulus(3'd6, OPC_OP, 3'd1, 7'd1, 5'd1, 5'd1, 5'd1, 32'd1);
    exp_err_cnt++;
    checkOutput("illegal6", NOP_INSTR, addr_of(9), 1'b1);

    @(posedge clk_i); #1;
    check32("drain.valid", {31'd0, valid_o}, 32'd0);
    check32("drain.instr", instr_o, NOP_INSTR);
    check32("drain.addr", addr_o, addr_of(9));

    ready_i = 1'b0;
    applyStimulus(FMT_I, OPC_OP_IMM, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd7);
    checkOutput("bpA", 32'h0070_0113, addr_of(10), 1'b0);
    set_fields(FMT_I, OPC_OP_IMM, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'd3);
    #1;
    check32("bp.ready0", {31'd0, ready_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      check32("bp.ready", {31'd0, ready_o}, 32'd0);
      checkOutput("bp.hold", 32'h0070_0113, addr_of(10), 1'b0);
    end
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    checkOutput("burstB", 32'h0030_0193, addr_of(11), 1'b0);
    set_fields(FMT_I, OPC_OP_IMM, 3'd0, 7'd0, 5'd4, 5'd0, 5'd0, 32'd4);
    @(posedge clk_i); #1;
    checkOutput("burstC", 32'h0040_0213, addr_of(12), 1'b0);
    set_fields(FMT_I, OPC_OP_IMM, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'd5);
    @(posedge clk_i); #1;
    checkOutput("burstD", 32'h0050_0293, addr_of(13), 1'b0);
    set_fields(FMT_I, OPC_OP_IMM, 3'd0, 7'd0, 5'd6, 5'd0, 5'd0, 32'd6);
    @(posedge clk_i); #1;
    checkOutput("burstE", 32'h0060_0313, addr_of(14), 1'b0);

    // 256 errored words saturate the 8-bit counter.
    set_fields(3'd7, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    repeat (256) @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    exp_err_cnt = 255;
    checkOutput("sat", NOP_INSTR, addr_of(270), 1'b1);

    rst_n_i = 1'b0;
    #1;
    check32("midrst.valid", {31'd0, valid_o}, 32'd0);
    check32("midrst.addr", addr_o, BASE);
    check32("midrst.errcnt", {24'd0, err_cnt_o}, 32'd0);
    #2 rst_n_i = 1'b1;
    exp_err_cnt = 0;
    @(posedge clk_i); #1;
    applyStimulus(FMT_I, OPC_OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    checkOutput("postrst", 32'h0050_0093, BASE, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
